// File: rtl/crash_detect_pkg.sv
// Shared defaults, types and helpers for the crash detection block.
// Holds the slot count, lives, invulnerability length and score width used by every file.
package crash_detect_pkg;

   localparam int ENEMY_NUM_DEF     = 8;
   localparam int IDX_W_DEF         = 3;
   localparam int LIVES_INIT_DEF    = 3;
   localparam int INVINC_FRAMES_DEF = 60;
   localparam int SCORE_W           = 16;
   localparam int LIVES_W           = 2;

   typedef logic [SCORE_W-1:0] score_t;

   // Per-pixel layer flags captured in the input stage.
   typedef struct packed {
      logic en;
      logic enemy;
      logic bullet;
      logic me;
   } px_flags_t;

   function automatic score_t score_sat_inc(input score_t s);
      return (s == '1) ? s : s + score_t'(1);
   endfunction

endpackage

// File: rtl/crash_detect_if.sv
// Pixel-layer inputs and game-state outputs of crash_detect, bundled as one interface.
// The slave modport is the detector's view; the master modport is the video pipeline's view.
interface crash_detect_if
   import crash_detect_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF
) ();

   logic               en_i;
   logic               v_sync_i;
   logic               enemy_alpha_i;
   logic [IDX_W-1:0]   enemy_idx_i;
   logic               bullet_alpha_i;
   logic               me_alpha_i;
   logic               crash_enemy_bullet_o;
   logic               crash_me_enemy_o;
   logic [IDX_W-1:0]   crash_idx_o;
   logic [LIVES_W-1:0] lives_o;
   score_t             score_o;
   logic               game_over_o;

   modport slave (
      input  en_i, v_sync_i, enemy_alpha_i, enemy_idx_i, bullet_alpha_i, me_alpha_i,
      output crash_enemy_bullet_o, crash_me_enemy_o, crash_idx_o, lives_o, score_o, game_over_o
   );

   modport master (
      output en_i, v_sync_i, enemy_alpha_i, enemy_idx_i, bullet_alpha_i, me_alpha_i,
      input  crash_enemy_bullet_o, crash_me_enemy_o, crash_idx_o, lives_o, score_o, game_over_o
   );

endinterface

// File: rtl/crash_detect_vsync_edge.sv
// Frame-start detector: registers v_sync_i and flags its rising edge for one cycle.
// The pulse lines up with the input-stage registers of the pixel flags in the parent.
module crash_detect_vsync_edge (
   input  logic clk_vga,
   input  logic rst,
   input  logic v_sync_i,
   output logic frame_start_o
);

   logic vs_q, vs_d;
   logic vs_prev_q, vs_prev_d;

   always_comb begin
      vs_d      = v_sync_i;
      vs_prev_d = vs_q;
   end

   always_ff @(posedge clk_vga or posedge rst) begin
      if (rst) begin
         vs_q      <= 1'b0;
         vs_prev_q <= 1'b0;
      end else begin
         vs_q      <= vs_d;
         vs_prev_q <= vs_prev_d;
      end
   end

   assign frame_start_o = vs_q & ~vs_prev_q;

endmodule

// File: rtl/crash_detect.sv
// Collision detector: bullet/enemy and player/enemy overlap pulses, score, lives, game over.
// Two-cycle latency: input sample register, then evaluation into registered outputs.
module crash_detect
   import crash_detect_pkg::*;
#(
   parameter int     ENEMY_NUM     = ENEMY_NUM_DEF,
   parameter int     IDX_W         = IDX_W_DEF,
   parameter int     LIVES_INIT    = LIVES_INIT_DEF,
   parameter int     INVINC_FRAMES = INVINC_FRAMES_DEF,
   parameter score_t SCORE_RST     = '0
) (
   input logic           clk_vga,
   input logic           rst,
   crash_detect_if.slave bus
);

   localparam int INV_W = (INVINC_FRAMES < 2) ? 1 : $clog2(INVINC_FRAMES + 1);
   typedef logic [INV_W-1:0] inv_t;

   logic                 frame_start;
   px_flags_t            px_q, px_d;
   logic [IDX_W-1:0]     idx_q, idx_d;

   logic [ENEMY_NUM-1:0] mask_q, mask_d, mask_eff;
   logic                 me_frame_q, me_frame_d, me_frame_eff;
   inv_t                 inv_q, inv_d, inv_eff;
   logic [LIVES_W-1:0]   lives_q, lives_d;
   score_t               score_q, score_d;
   logic                 game_over_q, game_over_d;
   logic                 eb_q, eb_d;
   logic                 me_q, me_d;
   logic [IDX_W-1:0]     crash_idx_q, crash_idx_d;
   logic                 active, hit_eb, hit_me;

   crash_detect_vsync_edge u_vsync_edge (
      .clk_vga       (clk_vga),
      .rst           (rst),
      .v_sync_i      (bus.v_sync_i),
      .frame_start_o (frame_start)
   );

   always_comb begin
      px_d.en     = bus.en_i;
      px_d.enemy  = bus.enemy_alpha_i;
      px_d.bullet = bus.bullet_alpha_i;
      px_d.me     = bus.me_alpha_i;
      idx_d       = bus.enemy_idx_i;
   end

   // Frame-start clears are applied before evaluation so an overlap on that cycle sees a fresh frame.
   always_comb begin
      active       = px_q.en & ~game_over_q & (lives_q != '0);
      mask_eff     = frame_start ? '0 : mask_q;
      me_frame_eff = frame_start ? 1'b0 : me_frame_q;
      inv_eff      = (frame_start && (inv_q != '0)) ? inv_q - inv_t'(1) : inv_q;
      hit_eb       = active & px_q.enemy & px_q.bullet & ~mask_eff[idx_q];
      hit_me       = active & px_q.enemy & px_q.me & ~me_frame_eff & (inv_eff == '0);
   end

   always_comb begin
      mask_d      = mask_q;
      me_frame_d  = me_frame_q;
      inv_d       = inv_q;
      lives_d     = lives_q;
      score_d     = score_q;
      if (active) begin
         mask_d     = mask_eff;
         me_frame_d = me_frame_eff;
         inv_d      = inv_eff;
         if (hit_eb) begin
            mask_d[idx_q] = 1'b1;
            score_d       = score_sat_inc(score_q);
         end
         if (hit_me) begin
            me_frame_d = 1'b1;
            inv_d      = inv_t'(INVINC_FRAMES);
            lives_d    = lives_q - LIVES_W'(1);
         end
      end
      eb_d        = hit_eb;
      me_d        = hit_me;
      crash_idx_d = (hit_eb | hit_me) ? idx_q : '0;
      game_over_d = game_over_q | (lives_q == '0);
   end

   always_ff @(posedge clk_vga or posedge rst) begin
      if (rst) begin
         px_q        <= '0;
         idx_q       <= '0;
         mask_q      <= '0;
         me_frame_q  <= 1'b0;
         inv_q       <= '0;
         lives_q     <= LIVES_W'(LIVES_INIT);
         score_q     <= SCORE_RST;
         game_over_q <= 1'b0;
         eb_q        <= 1'b0;
         me_q        <= 1'b0;
         crash_idx_q <= '0;
      end else begin
         px_q        <= px_d;
         idx_q       <= idx_d;
         mask_q      <= mask_d;
         me_frame_q  <= me_frame_d;
         inv_q       <= inv_d;
         lives_q     <= lives_d;
         score_q     <= score_d;
         game_over_q <= game_over_d;
         eb_q        <= eb_d;
         me_q        <= me_d;
         crash_idx_q <= crash_idx_d;
      end
   end

   assign bus.crash_enemy_bullet_o = eb_q;
   assign bus.crash_me_enemy_o     = me_q;
   assign bus.crash_idx_o          = crash_idx_q;
   assign bus.lives_o              = lives_q;
   assign bus.score_o              = score_q;
   assign bus.game_over_o          = game_over_q;

endmodule

// File: tb/tb_crash_detect.sv
// Scoreboard bench for crash_detect: a frame-numbered reference model queues expected pulses,
// a negedge monitor pops and compares them whenever the DUT pulses.
module tb_crash_detect;
   import crash_detect_pkg::*;

   localparam int INV    = 60;
   localparam int LIVES0 = 3;

   logic clk_vga = 1'b0;
   logic rst     = 1'b1;
   always #5 clk_vga = ~clk_vga;

   crash_detect_if #(.IDX_W(3)) bus ();
   crash_detect_if #(.IDX_W(3)) bus_sat ();

   crash_detect #(.ENEMY_NUM(8), .IDX_W(3), .LIVES_INIT(LIVES0), .INVINC_FRAMES(INV)) dut (
      .clk_vga (clk_vga),
      .rst     (rst),
      .bus     (bus)
   );

   crash_detect #(.ENEMY_NUM(8), .IDX_W(3), .LIVES_INIT(LIVES0), .INVINC_FRAMES(INV),
                  .SCORE_RST(16'hFFFF)) dut_sat (
      .clk_vga (clk_vga),
      .rst     (rst),
      .bus     (bus_sat)
   );

   int cyc = 0;
   always @(posedge clk_vga) cyc <= cyc + 1;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input longint got, input longint exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
   endtask

   // Reference model: frames are numbered, each slot remembers the frame of its last hit.
   int m_frame;
   int m_last_hit[8];
   int m_last_me;
   int m_lives;
   int m_score;
   bit m_dead;
   bit m_prev_vs;

   typedef struct {
      int due;
      bit eb;
      bit me;
      int idx;
      int score;
      int lives;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   function automatic void model_reset();
      m_frame   = 0;
      foreach (m_last_hit[i]) m_last_hit[i] = -1;
      m_last_me = -1000;
      m_lives   = LIVES0;
      m_score   = 0;
      m_dead    = 1'b0;
      m_prev_vs = 1'b0;
   endfunction

   function automatic void model_step(input bit en, input bit vs, input bit ea, input int idx,
                                      input bit ba, input bit ma);
      bit   rise;
      exp_t e;
      rise      = vs && !m_prev_vs;
      m_prev_vs = vs;
      if (!en || m_dead) return;
      if (rise) m_frame++;
      e.eb = ea && ba && (m_last_hit[idx] != m_frame);
      e.me = ea && ma && (m_frame - m_last_me >= INV);
      if (e.eb) begin
         m_last_hit[idx] = m_frame;
         if (m_score < 65535) m_score++;
      end
      if (e.me) begin
         m_last_me = m_frame;
         m_lives--;
         if (m_lives == 0) m_dead = 1'b1;
      end
      if (e.eb || e.me) begin
         e.due   = cyc + 2;
         e.idx   = idx;
         e.score = m_score;
         e.lives = m_lives;
         sb.push_back(e);
      end
   endfunction

   task automatic drive(input bit en, input bit vs, input bit ea, input int idx,
                        input bit ba, input bit ma);
      @(posedge clk_vga);
      #1;
      bus.en_i           = en;
      bus.v_sync_i       = vs;
      bus.enemy_alpha_i  = ea;
      bus.enemy_idx_i    = 3'(idx);
      bus.bullet_alpha_i = ba;
      bus.me_alpha_i     = ma;
      model_step(en, vs, ea, idx, ba, ma);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(posedge clk_vga);
      #1;
      rst = 1'b1;
      bus.en_i = 1'b0; bus.v_sync_i = 1'b0; bus.enemy_alpha_i = 1'b0;
      bus.enemy_idx_i = '0; bus.bullet_alpha_i = 1'b0; bus.me_alpha_i = 1'b0;
      sb.delete();
      repeat (3) @(posedge clk_vga);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic check_reset_vals(input string tag);
      @(negedge clk_vga);
      check({tag, "_eb_pulse"}, bus.crash_enemy_bullet_o, 0);
      check({tag, "_me_pulse"}, bus.crash_me_enemy_o, 0);
      check({tag, "_crash_idx"}, bus.crash_idx_o, 0);
      check({tag, "_lives"}, bus.lives_o, LIVES0);
      check({tag, "_score"}, bus.score_o, 0);
      check({tag, "_game_over"}, bus.game_over_o, 0);
   endtask

   always @(negedge clk_vga) begin
      if (!rst) begin
         if (bus.crash_enemy_bullet_o || bus.crash_me_enemy_o) begin
            if (sb.size() == 0) begin
               check("spurious_pulse", {bus.crash_enemy_bullet_o, bus.crash_me_enemy_o}, 0);
            end else begin
               mon_e = sb.pop_front();
               check("pulse_cycle", cyc, mon_e.due);
               check("eb_pulse", bus.crash_enemy_bullet_o, mon_e.eb);
               check("me_pulse", bus.crash_me_enemy_o, mon_e.me);
               check("crash_idx", bus.crash_idx_o, mon_e.idx);
               check("score_at_pulse", bus.score_o, mon_e.score);
               check("lives_at_pulse", bus.lives_o, mon_e.lives);
            end
         end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            check("missing_pulse", {bus.crash_enemy_bullet_o, bus.crash_me_enemy_o},
                  {mon_e.eb, mon_e.me});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_sat.en_i = 1'b0; bus_sat.v_sync_i = 1'b0; bus_sat.enemy_alpha_i = 1'b0;
      bus_sat.enemy_idx_i = '0; bus_sat.bullet_alpha_i = 1'b0; bus_sat.me_alpha_i = 1'b0;
      model_reset();
      do_reset();
      check_reset_vals("reset");
      check("sat_reset_score", bus_sat.score_o, 65535);

      // One bullet hit per slot per frame, then a fresh frame allows another.
      drive(1, 1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(1, 0, 1, 5, 1, 0);
      idle(3);
      @(negedge clk_vga);
      check("score_frame0", bus.score_o, 1);
      drive(1, 1, 0, 0, 0, 0);
      drive(1, 0, 1, 5, 1, 0);
      drive(1, 0, 1, 5, 1, 0);
      drive(1, 0, 1, 2, 1, 0);
      idle(3);
      @(negedge clk_vga);
      check("score_frame1", bus.score_o, 3);

      // All three layers opaque on slot 7, then an overlap on the frame-start cycle itself.
      drive(1, 1, 0, 0, 0, 0);
      drive(1, 0, 1, 7, 1, 1);
      drive(1, 0, 1, 7, 1, 0);
      drive(1, 1, 1, 7, 1, 0);
      drive(0, 0, 1, 3, 1, 1);
      idle(3);
      @(negedge clk_vga);
      check("lives_after_me_hit", bus.lives_o, 2);
      check("score_after_rise_hit", bus.score_o, 5);

      for (int f = 0; f < 30; f++) begin
         for (int k = 0; k < 16; k++) begin
            drive(($urandom % 8) != 0, k < 2, $urandom % 2, $urandom % 8,
                  ($urandom % 3) == 0, ($urandom % 16) == 0);
         end
      end
      idle(3);
      @(negedge clk_vga);
      check("random_score", bus.score_o, m_score);
      check("random_lives", bus.lives_o, m_lives);

      // Invulnerability window and game over.
      do_reset();
      drive(1, 0, 1, 1, 0, 1);
      for (int fr = 1; fr <= 120; fr++) begin
         drive(1, 1, 0, 0, 0, 0);
         drive(1, 0, 1, fr % 8, 0, 1);
         if (fr == 60) begin
            idle(3);
            @(negedge clk_vga);
            check("lives_after_frame60", bus.lives_o, 1);
         end
      end
      idle(1);
      repeat (2) @(negedge clk_vga);
      check("lives_at_third_hit", bus.lives_o, 0);
      check("game_over_same_cycle", bus.game_over_o, 0);
      @(negedge clk_vga);
      check("game_over_next_cycle", bus.game_over_o, 1);
      drive(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(1, 0, 1, i, 1, 1);
      idle(3);
      @(negedge clk_vga);
      check("score_frozen", bus.score_o, m_score);
      check("game_over_sticky", bus.game_over_o, 1);

      // Reset one cycle after an overlap discards it.
      do_reset();
      drive(1, 0, 1, 4, 1, 1);
      do_reset();
      idle(5);
      check_reset_vals("midrst");

      // Saturated score stays at its maximum on a hit.
      @(posedge clk_vga);
      #1;
      bus_sat.en_i = 1'b1; bus_sat.enemy_alpha_i = 1'b1;
      bus_sat.bullet_alpha_i = 1'b1; bus_sat.enemy_idx_i = 3'd3;
      @(posedge clk_vga);
      #1;
      bus_sat.enemy_alpha_i = 1'b0; bus_sat.bullet_alpha_i = 1'b0;
      repeat (2) @(negedge clk_vga);
      check("sat_pulse", bus_sat.crash_enemy_bullet_o, 1);
      check("sat_idx", bus_sat.crash_idx_o, 3);
      check("sat_score", bus_sat.score_o, 65535);

      idle(4);
      @(negedge clk_vga);
      check("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
